// File: rtl/read_line_assembler.sv
// Assembles BL/2 deserialized words into one read line. Each line is tagged with
// the address of the READ that produced it; the capture window is timed from rd_issue.
module read_line_assembler #(
  parameter int unsigned BW  = 8,
  parameter int unsigned BL  = 8,
  parameter int unsigned LAT = 6,
  parameter int unsigned AW  = 27
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               rd_issue,
  input  logic [AW-1:0]      rd_addr,
  input  logic [2*BW-1:0]    word_in,
  output logic [BW*BL-1:0]   rd_data,
  output logic [AW-1:0]      rd_addr_out,
  output logic               rd_valid,
  output logic               busy,
  output logic               overlap_err
);

  localparam int unsigned WW = 2 * BW;
  localparam int unsigned NW = BL / 2;
  localparam int unsigned KW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [KW-1:0] LAST = KW'(NW - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t              state;
  logic [KW-1:0]       k;
  logic [BW*BL-1:0]    line_buf;
  logic [BW*BL-1:0]    next_line;
  logic [AW-1:0]       tag;
  logic                start;
  logic [AW-1:0]       start_addr;
  logic                pipe_busy;

  // The FSM reacts to start one clock before the first word, so the final stage of
  // the latency line is the combinational tap on the last register (LAT-1 registers).
  if (LAT == 1) begin : g_no_pipe
    assign start      = rd_issue;
    assign start_addr = rd_addr;
    assign pipe_busy  = 1'b0;
  end else begin : g_pipe
    logic [LAT-2:0] pv;
    logic [AW-1:0]  pa [LAT-1];

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        pv <= '0;
      end else begin
        pv[0] <= rd_issue;
        for (int unsigned i = 1; i < LAT - 1; i++) pv[i] <= pv[i-1];
      end
    end

    always_ff @(posedge clock) begin
      pa[0] <= rd_addr;
      for (int unsigned i = 1; i < LAT - 1; i++) pa[i] <= pa[i-1];
    end

    assign start      = pv[LAT-2];
    assign start_addr = pa[LAT-2];
    assign pipe_busy  = |pv;
  end

  always_comb begin
    next_line = line_buf;
    for (int unsigned i = 0; i < NW; i++) begin
      if (k == KW'(i)) next_line[i*WW +: WW] = word_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      k           <= '0;
      line_buf    <= '0;
      tag         <= '0;
      rd_data     <= '0;
      rd_addr_out <= '0;
      rd_valid    <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == COLLECT) begin
        line_buf <= next_line;
        if (k == LAST) begin
          rd_data     <= next_line;
          rd_addr_out <= tag;
          rd_valid    <= 1'b1;
          state       <= IDLE;
          k           <= '0;
        end else begin
          k <= k + KW'(1);
        end
      end
      // A start on the final word chains seamlessly; any earlier start aborts the line.
      if (start) begin
        if (state == COLLECT && k != LAST) overlap_err <= 1'b1;
        if (state == COLLECT && k != LAST) rd_valid <= 1'b0;
        state <= COLLECT;
        k     <= '0;
        tag   <= start_addr;
      end
    end
  end

  assign busy = pipe_busy | (state == COLLECT);

endmodule

// File: tb/tb_read_line_assembler.sv
// Bench for read_line_assembler: table of tagged READs plus hand-written corner sequences,
// with a scoreboard queue of expected lines popped on each rd_valid.
module tb_read_line_assembler;

  localparam int unsigned BW  = 8;
  localparam int unsigned BL  = 8;
  localparam int unsigned LAT = 6;
  localparam int unsigned AW  = 27;
  localparam int          DONE = LAT + BL / 2;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               rd_issue = 1'b0;
  logic [AW-1:0]      rd_addr = '0;
  logic [2*BW-1:0]    word_in = '0;
  logic [BW*BL-1:0]   rd_data;
  logic [AW-1:0]      rd_addr_out;
  logic               rd_valid;
  logic               busy;
  logic               overlap_err;

  read_line_assembler #(.BW(BW), .BL(BL), .LAT(LAT), .AW(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_issue    (rd_issue),
    .rd_addr     (rd_addr),
    .word_in     (word_in),
    .rd_data     (rd_data),
    .rd_addr_out (rd_addr_out),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .overlap_err (overlap_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0]   data;
    logic [AW-1:0] addr;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   w [4];
    logic [63:0]   line;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    step();
    reset_n  = 1'b0;
    rd_issue = 1'b0;
    word_in  = 16'($urandom);
    @(negedge clock);
    step();
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_rd_addr_out", 64'(rd_addr_out), 64'h0);
    chk("reset_rd_valid", 64'(rd_valid), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_overlap_err", 64'(overlap_err), 64'h0);
    sb.delete();
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid at cycle %0d: got rd_valid=1 tag=%0h expected no line", cyc, rd_addr_out);
      end else begin
        e = sb.pop_front();
        chk("line_data", rd_data, e.data);
        chk("line_tag", 64'(rd_addr_out), 64'(e.addr));
        chk("line_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] sw [4];
    logic [63:0] ov_line;
    int b;
    int idx;

    tbl[0] = '{27'h0000001, '{16'h1100, 16'h3322, 16'h5544, 16'h7766}, 64'h7766554433221100};
    tbl[1] = '{27'h0000002, '{16'hBEEF, 16'hDEAD, 16'hCAFE, 16'hF00D}, 64'hF00DCAFEDEADBEEF};
    tbl[2] = '{27'h7FFFFFF, '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}, 64'h0000FFFF0000FFFF};
    tbl[3] = '{27'h4000000, '{16'h0001, 16'h0002, 16'h0004, 16'h0008}, 64'h0008000400020001};
    tbl[4] = '{27'h0ABCDEF, '{16'h8000, 16'h4000, 16'h2000, 16'h1000}, 64'h1000200040008000};
    tbl[5] = '{27'h5555555, '{16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0}, 64'hF0F00F0F5A5AA5A5};
    tbl[6] = '{27'h2AAAAAA, '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 64'hDEF09ABC56781234};
    tbl[7] = '{27'h0000000, '{16'h0000, 16'h0000, 16'h0000, 16'h0001}, 64'h0001000000000000};
    sw = '{16'hA1A0, 16'hA3A2, 16'hA5A4, 16'hA7A6};

    do_reset();

    // Idle data must be ignored.
    for (int t = 0; t < 50; t++) begin
      step();
      word_in = 16'($urandom);
      @(negedge clock);
      chk("idle_rd_valid", 64'(rd_valid), 64'h0);
      chk("idle_rd_data", rd_data, 64'h0);
    end
    chk("idle_busy", 64'(busy), 64'h0);

    // Single READ with busy window and hold after completion.
    b = cyc + 1;
    for (int t = 0; t <= 14; t++) begin
      step();
      rd_issue = (t == 0);
      rd_addr  = 27'h0000123;
      word_in  = (t >= LAT && t < DONE) ? sw[t - LAT] : 16'($urandom);
      if (t == 0) sb.push_back('{64'hA7A6A5A4A3A2A1A0, 27'h0000123, b + DONE});
      @(negedge clock);
      chk("single_busy", 64'(busy), 64'(t >= 1 && t <= DONE - 1));
      chk("single_valid", 64'(rd_valid), 64'(t == DONE));
    end
    chk("single_hold_data", rd_data, 64'hA7A6A5A4A3A2A1A0);
    chk("single_hold_tag", 64'(rd_addr_out), 64'h123);
    chk("single_pending", 64'(sb.size()), 64'h0);

    // Table: eight READs every BL/2 cycles, back to back.
    b = cyc + 1;
    for (int t = 0; t <= 28 + DONE + 2; t++) begin
      step();
      rd_issue = (t % 4 == 0) && (t < 32);
      if (rd_issue) begin
        rd_addr = tbl[t / 4].addr;
        sb.push_back('{tbl[t / 4].line, tbl[t / 4].addr, b + t + DONE});
      end
      idx = t - LAT;
      word_in = (idx >= 0 && idx < 32) ? tbl[idx / 4].w[idx % 4] : 16'($urandom);
      @(negedge clock);
      chk("b2b_busy", 64'(busy), 64'(t >= 1 && t <= 28 + DONE - 1));
      chk("b2b_overlap_err", 64'(overlap_err), 64'h0);
    end
    chk("b2b_pending", 64'(sb.size()), 64'h0);

    // Overlap violation: second READ two cycles after the first.
    b = cyc + 1;
    ov_line = '0;
    for (int t = 0; t <= 16; t++) begin
      step();
      rd_issue = (t == 0) || (t == 2);
      rd_addr  = (t == 0) ? 27'h1 : 27'h2;
      word_in  = 16'($urandom);
      if (t >= LAT + 2 && t < DONE + 2) ov_line[(t - LAT - 2) * 16 +: 16] = word_in;
      if (t == DONE + 1) sb.push_back('{ov_line, 27'h2, b + DONE + 2});
      @(negedge clock);
      chk("ovl_err", 64'(overlap_err), 64'(t >= LAT + 2));
      chk("ovl_valid", 64'(rd_valid), 64'(t == DONE + 2));
    end
    chk("ovl_pending", 64'(sb.size()), 64'h0);
    do_reset();

    // Reset during collection discards the READ.
    for (int t = 0; t <= 20; t++) begin
      step();
      rd_issue = (t == 0);
      rd_addr  = 27'h0000456;
      reset_n  = (t != 7);
      word_in  = 16'($urandom);
      @(negedge clock);
      chk("midrst_valid", 64'(rd_valid), 64'h0);
      if (t >= 8) begin
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_data", rd_data, 64'h0);
      end
      if (t == 8) begin
        chk("midrst_tag", 64'(rd_addr_out), 64'h0);
        chk("midrst_overlap_err", 64'(overlap_err), 64'h0);
      end
    end
    chk("midrst_pending", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
